// File: rtl/spi_flash_multiloader.sv
// spi_flash_multiloader
//   Copies up to `segments` regions from a flash slot into on-chip memory,
//   one region after another. Each region is read with a plain 0x03 read
//   command under its own chip-select window. Bytes come from the SPI byte
//   engine over a toggle req/ack handshake and are written to memory over a
//   second toggle req/ack handshake. Only one byte is in flight at a time.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   start, slot         load request pulse and flash slot (latched at start)
//   seg_flash_offset    per-segment byte offset in slot, 24 bits each
//   seg_start_addr      per-segment destination base, a_bits each
//   seg_amount          per-segment byte count, 16 bits each (0 = skip)
//   busy, done, seg     status: running, sticky completion, current segment
//   cs_n, spi_req/ack   flash chip select and SPI byte handshake
//   spi_d, spi_q        byte shifted out / byte shifted in
//   req/ack, a, q       memory write handshake, address and data
//
// state | meaning
// IDLE  | waiting for start
// NEXT  | inspect descriptor of segment seg, open cs_n or skip it
// CMD   | send read command 0x03
// ADDR2 | send faddr[23:16]
// ADDR1 | send faddr[15:8]
// ADDR0 | send faddr[7:0]
// READ  | clock in one data byte with 0xFF
// WRITE | wait for memory write ack
// GAP   | cs_n high between segments
// DONE  | set done, drop busy
module spi_flash_multiloader #(
    parameter int a_bits     = 14,
    parameter int segments   = 2,
    parameter int slot_shift = 20,
    parameter int cs_gap     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [3:0]                 slot,
    input  logic [segments*24-1:0]     seg_flash_offset,
    input  logic [segments*a_bits-1:0] seg_start_addr,
    input  logic [segments*16-1:0]     seg_amount,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 seg,
    output logic                       cs_n,
    output logic                       spi_req,
    input  logic                       spi_ack,
    output logic [7:0]                 spi_d,
    input  logic [7:0]                 spi_q,
    output logic                       req,
    input  logic                       ack,
    output logic [a_bits-1:0]          a,
    output logic [7:0]                 q
);

    localparam int GW = (cs_gap > 1) ? $clog2(cs_gap) : 1;

    typedef enum logic [3:0] {
        IDLE, NEXT, CMD, ADDR2, ADDR1, ADDR0, READ, WRITE, GAP, DONE
    } state_t;

    state_t            state, state_n;
    logic              busy_n, done_n, cs_n_n, spi_req_n, req_n;
    logic [2:0]        seg_n;
    logic [7:0]        spi_d_n, q_n;
    logic [a_bits-1:0] a_n, maddr, maddr_n;
    logic [3:0]        slot_r, slot_r_n;
    logic [23:0]       faddr, faddr_n, slot_base;
    logic [15:0]       count, count_n;
    logic              sent, sent_n;
    logic [GW-1:0]     gap_cnt, gap_cnt_n;

    // Descriptor tables padded to 8 entries so the 3-bit seg index is exact.
    logic [23:0]       off_tab  [8];
    logic [a_bits-1:0] addr_tab [8];
    logic [15:0]       amt_tab  [8];

    for (genvar i = 0; i < 8; i++) begin : g_tab
        if (i < segments) begin : g_used
            assign off_tab[i]  = seg_flash_offset[24*i +: 24];
            assign addr_tab[i] = seg_start_addr[a_bits*i +: a_bits];
            assign amt_tab[i]  = seg_amount[16*i +: 16];
        end else begin : g_unused
            assign off_tab[i]  = '0;
            assign addr_tab[i] = '0;
            assign amt_tab[i]  = '0;
        end
    end

    assign slot_base = 24'(slot_r) << slot_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            seg     <= '0;
            cs_n    <= 1'b1;
            spi_req <= 1'b0;
            spi_d   <= '0;
            req     <= 1'b0;
            a       <= '0;
            q       <= '0;
            slot_r  <= '0;
            faddr   <= '0;
            maddr   <= '0;
            count   <= '0;
            sent    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            busy    <= busy_n;
            done    <= done_n;
            seg     <= seg_n;
            cs_n    <= cs_n_n;
            spi_req <= spi_req_n;
            spi_d   <= spi_d_n;
            req     <= req_n;
            a       <= a_n;
            q       <= q_n;
            slot_r  <= slot_r_n;
            faddr   <= faddr_n;
            maddr   <= maddr_n;
            count   <= count_n;
            sent    <= sent_n;
            gap_cnt <= gap_cnt_n;
        end
    end

    logic   advance;
    logic [7:0] byte_out;
    state_t follow;

    always_comb begin
        state_n   = state;
        busy_n    = busy;
        done_n    = done;
        seg_n     = seg;
        cs_n_n    = cs_n;
        spi_req_n = spi_req;
        spi_d_n   = spi_d;
        req_n     = req;
        a_n       = a;
        q_n       = q;
        slot_r_n  = slot_r;
        faddr_n   = faddr;
        maddr_n   = maddr;
        count_n   = count;
        sent_n    = sent;
        gap_cnt_n = gap_cnt;
        advance   = 1'b0;
        byte_out  = 8'hFF;
        follow    = IDLE;

        case (state)
            IDLE: begin
                if (start) begin
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    seg_n    = '0;
                    slot_r_n = slot;
                    state_n  = NEXT;
                end
            end
            NEXT: begin
                if (amt_tab[seg] == '0) begin
                    advance = 1'b1;
                end else begin
                    faddr_n = slot_base + off_tab[seg];
                    maddr_n = addr_tab[seg];
                    count_n = amt_tab[seg];
                    cs_n_n  = 1'b0;
                    sent_n  = 1'b0;
                    state_n = CMD;
                end
            end
            CMD, ADDR2, ADDR1, ADDR0, READ: begin
                case (state)
                    CMD:     begin byte_out = 8'h03;         follow = ADDR2; end
                    ADDR2:   begin byte_out = faddr[23:16];  follow = ADDR1; end
                    ADDR1:   begin byte_out = faddr[15:8];   follow = ADDR0; end
                    ADDR0:   begin byte_out = faddr[7:0];    follow = READ;  end
                    default: begin byte_out = 8'hFF;         follow = WRITE; end
                endcase
                // sent separates "not yet issued" from "issued and acked",
                // since both look like spi_ack == spi_req.
                if (!sent) begin
                    spi_d_n   = byte_out;
                    spi_req_n = ~spi_req;
                    sent_n    = 1'b1;
                end else if (spi_ack == spi_req) begin
                    sent_n  = 1'b0;
                    state_n = follow;
                    if (state == READ) begin
                        q_n   = spi_q;
                        a_n   = maddr;
                        req_n = ~req;
                    end
                end
            end
            WRITE: begin
                if (ack == req) begin
                    maddr_n = maddr + 1'b1;
                    count_n = count - 16'd1;
                    if (count == 16'd1) begin
                        cs_n_n = 1'b1;
                        // NEXT contributes one more high cycle, so GAP lasts cs_gap-1.
                        if (cs_gap > 1) begin
                            gap_cnt_n = GW'(cs_gap - 2);
                            state_n   = GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        state_n = READ;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) advance = 1'b1;
                else               gap_cnt_n = gap_cnt - GW'(1);
            end
            DONE: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                cs_n_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (advance) begin
            if (seg == 3'(segments - 1)) begin
                state_n = DONE;
            end else begin
                seg_n   = seg + 3'd1;
                state_n = NEXT;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_multiloader.sv
// Directed bench for spi_flash_multiloader with a small flash model on the
// SPI side and a logging memory model on the write side.
module tb_spi_flash_multiloader;
    localparam int A_BITS = 14;
    localparam int SEGS   = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [3:0]             slot = '0;
    logic [SEGS*24-1:0]     seg_flash_offset = '0;
    logic [SEGS*A_BITS-1:0] seg_start_addr = '0;
    logic [SEGS*16-1:0]     seg_amount = '0;
    logic                   busy, done, cs_n, spi_req, spi_ack, req, ack;
    logic [2:0]             seg;
    logic [7:0]             spi_d, spi_q, q;
    logic [A_BITS-1:0]      a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_flash_multiloader #(.a_bits(A_BITS), .segments(SEGS), .slot_shift(20), .cs_gap(4)) dut (
        .clk(clk), .reset(reset), .start(start), .slot(slot),
        .seg_flash_offset(seg_flash_offset), .seg_start_addr(seg_start_addr),
        .seg_amount(seg_amount), .busy(busy), .done(done), .seg(seg),
        .cs_n(cs_n), .spi_req(spi_req), .spi_ack(spi_ack), .spi_d(spi_d),
        .spi_q(spi_q), .req(req), .ack(ack), .a(a), .q(q)
    );

    logic [7:0]        flash_mem [logic [23:0]];
    bit                rand_dly = 1'b0;
    logic [7:0]        spi_log [$];
    logic [A_BITS-1:0] wr_a [$];
    logic [7:0]        wr_q [$];
    logic [2:0]        wr_seg [$];

    function automatic logic [7:0] flash_rd(input logic [23:0] x);
        return flash_mem.exists(x) ? flash_mem[x] : 8'h00;
    endfunction

    // SPI flash model: byte 0 command, bytes 1..3 address, then data.
    logic        spi_pend = 1'b0, spi_req_d = 1'b0;
    int          spi_wait = 0, spi_idx = 0, spi_viol = 0;
    logic [23:0] fa = '0;
    logic [7:0]  spi_resp = '0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_ack   <= 1'b0;
            spi_q     <= '0;
            spi_pend  <= 1'b0;
            spi_req_d <= 1'b0;
            spi_idx   <= 0;
        end else begin
            spi_req_d <= spi_req;
            if (spi_req != spi_req_d && spi_req_d != spi_ack) spi_viol++;
            if (spi_req != spi_req_d && req != ack) spi_viol++;
            if (!spi_pend && spi_req != spi_ack) begin
                spi_log.push_back(spi_d);
                if (cs_n) spi_viol++;
                spi_pend <= 1'b1;
                spi_wait <= rand_dly ? int'($urandom_range(0, 7)) : 0;
                spi_idx  <= spi_idx + 1;
                case (spi_idx)
                    0: spi_resp <= 8'hE7;
                    1: begin fa[23:16] <= spi_d; spi_resp <= 8'hE7; end
                    2: begin fa[15:8]  <= spi_d; spi_resp <= 8'hE7; end
                    3: begin fa[7:0]   <= spi_d; spi_resp <= 8'hE7; end
                    default: begin spi_resp <= flash_rd(fa); fa <= fa + 24'd1; end
                endcase
            end else if (spi_pend) begin
                if (spi_wait == 0) begin
                    spi_ack  <= spi_req;
                    spi_q    <= spi_resp;
                    spi_pend <= 1'b0;
                end else begin
                    spi_wait <= spi_wait - 1;
                end
            end
            if (cs_n) spi_idx <= 0;
        end
    end

    logic mem_pend = 1'b0, req_d = 1'b0;
    int   mem_wait = 0, mem_viol = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ack      <= 1'b0;
            mem_pend <= 1'b0;
            req_d    <= 1'b0;
        end else begin
            req_d <= req;
            if (req != req_d && req_d != ack) mem_viol++;
            if (!mem_pend && req != ack) begin
                wr_a.push_back(a);
                wr_q.push_back(q);
                wr_seg.push_back(seg);
                mem_pend <= 1'b1;
                mem_wait <= rand_dly ? int'($urandom_range(0, 7)) : 0;
            end else if (mem_pend) begin
                if (mem_wait == 0) begin
                    ack      <= req;
                    mem_pend <= 1'b0;
                end else begin
                    mem_wait <= mem_wait - 1;
                end
            end
        end
    end

    // Chip-select windows and the high run before each falling edge.
    int   cs_falls = 0, last_gap = 0, hi_run = 0;
    logic cs_prev = 1'b1;
    always @(negedge clk) begin
        if (cs_prev && !cs_n) begin
            cs_falls++;
            last_gap = hi_run;
        end
        hi_run  = cs_n ? hi_run + 1 : 0;
        cs_prev = cs_n;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_spi(input int i, input logic [7:0] e);
        if (i < spi_log.size()) chk("spi_byte", 32'(spi_log[i]), 32'(e));
        else                    chk("spi_present", 32'(spi_log.size()), 32'(i + 1));
    endtask

    task automatic chk_wr(input int i, input logic [A_BITS-1:0] ea, input logic [7:0] eq,
                          input logic [2:0] es);
        if (i < wr_a.size()) begin
            chk("wr_addr", 32'(wr_a[i]), 32'(ea));
            chk("wr_data", 32'(wr_q[i]), 32'(eq));
            chk("wr_seg",  32'(wr_seg[i]), 32'(es));
        end else begin
            chk("wr_present", 32'(wr_a.size()), 32'(i + 1));
        end
    endtask

    task automatic set_seg(input int i, input logic [23:0] off, input logic [A_BITS-1:0] addr,
                           input logic [15:0] amt);
        seg_flash_offset[24*i +: 24]       = off;
        seg_start_addr[A_BITS*i +: A_BITS] = addr;
        seg_amount[16*i +: 16]             = amt;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("done_within_budget", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin : main
        int sb, wb, cb, busy_cnt;
        logic [7:0] e2 [13];
        e2 = '{8'h03, 8'h20, 8'h00, 8'h00, 8'hFF, 8'hFF,
               8'h03, 8'h20, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hFF};

        flash_mem[24'h200100] = 8'hAA; flash_mem[24'h200101] = 8'hBB;
        flash_mem[24'h200102] = 8'hCC; flash_mem[24'h200103] = 8'hDD;
        flash_mem[24'h200000] = 8'h11; flash_mem[24'h200001] = 8'h22;
        flash_mem[24'h200010] = 8'h33; flash_mem[24'h200011] = 8'h44;
        flash_mem[24'h200012] = 8'h55;
        flash_mem[24'h300020] = 8'h5C;
        flash_mem[24'h000200] = 8'h01; flash_mem[24'h000201] = 8'h02;
        flash_mem[24'h000202] = 8'h03; flash_mem[24'h000203] = 8'h04;

        // reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_spi_req", 32'(spi_req), 32'd0);
        chk("rst_spi_d", 32'(spi_d), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);

        // single region: slot 2, offset 0x100, 4 bytes to address 0
        slot = 4'd2;
        set_seg(0, 24'h000100, 14'h0000, 16'd4);
        set_seg(1, 24'h000000, 14'h0000, 16'd0);
        sb = spi_log.size(); wb = wr_a.size(); cb = cs_falls;
        pulse_start();
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        chk("t1_done_cleared", 32'(done), 32'd0);
        wait_done(500);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk_spi(sb + 0, 8'h03); chk_spi(sb + 1, 8'h20); chk_spi(sb + 2, 8'h01);
        chk_spi(sb + 3, 8'h00);
        for (int i = 4; i < 8; i++) chk_spi(sb + i, 8'hFF);
        chk("t1_spi_count", 32'(spi_log.size() - sb), 32'd8);
        chk_wr(wb + 0, 14'h0000, 8'hAA, 3'd0); chk_wr(wb + 1, 14'h0001, 8'hBB, 3'd0);
        chk_wr(wb + 2, 14'h0002, 8'hCC, 3'd0); chk_wr(wb + 3, 14'h0003, 8'hDD, 3'd0);
        chk("t1_wr_count", 32'(wr_a.size() - wb), 32'd4);
        chk("t1_cs_windows", 32'(cs_falls - cb), 32'd1);
        chk("t1_seg_last", 32'(seg), 32'd1);

        // two regions, 4 high cycles between cs windows
        set_seg(0, 24'h000000, 14'h1000, 16'd2);
        set_seg(1, 24'h000010, 14'h2000, 16'd3);
        sb = spi_log.size(); wb = wr_a.size(); cb = cs_falls;
        pulse_start();
        wait_done(800);
        for (int i = 0; i < 13; i++) chk_spi(sb + i, e2[i]);
        chk("t2_spi_count", 32'(spi_log.size() - sb), 32'd13);
        chk_wr(wb + 0, 14'h1000, 8'h11, 3'd0); chk_wr(wb + 1, 14'h1001, 8'h22, 3'd0);
        chk_wr(wb + 2, 14'h2000, 8'h33, 3'd1); chk_wr(wb + 3, 14'h2001, 8'h44, 3'd1);
        chk_wr(wb + 4, 14'h2002, 8'h55, 3'd1);
        chk("t2_wr_count", 32'(wr_a.size() - wb), 32'd5);
        chk("t2_cs_windows", 32'(cs_falls - cb), 32'd2);
        chk("t2_cs_gap", 32'(last_gap), 32'd4);

        // first region empty: one window, one write
        slot = 4'd3;
        set_seg(0, 24'h000000, 14'h0000, 16'd0);
        set_seg(1, 24'h000020, 14'h0050, 16'd1);
        sb = spi_log.size(); wb = wr_a.size(); cb = cs_falls;
        pulse_start();
        wait_done(500);
        chk_spi(sb + 0, 8'h03); chk_spi(sb + 1, 8'h30); chk_spi(sb + 2, 8'h00);
        chk_spi(sb + 3, 8'h20); chk_spi(sb + 4, 8'hFF);
        chk_wr(wb + 0, 14'h0050, 8'h5C, 3'd1);
        chk("t3_wr_count", 32'(wr_a.size() - wb), 32'd1);
        chk("t3_cs_windows", 32'(cs_falls - cb), 32'd1);

        // destination address wraps at 2^14
        slot = 4'd0;
        set_seg(0, 24'h000200, 14'h3FFE, 16'd4);
        set_seg(1, 24'h000000, 14'h0000, 16'd0);
        sb = spi_log.size(); wb = wr_a.size();
        pulse_start();
        wait_done(500);
        chk_spi(sb + 1, 8'h00); chk_spi(sb + 2, 8'h02); chk_spi(sb + 3, 8'h00);
        chk_wr(wb + 0, 14'h3FFE, 8'h01, 3'd0); chk_wr(wb + 1, 14'h3FFF, 8'h02, 3'd0);
        chk_wr(wb + 2, 14'h0000, 8'h03, 3'd0); chk_wr(wb + 3, 14'h0001, 8'h04, 3'd0);

        // all regions empty: busy after the start cycle for segments+1 cycles
        // (segments+2 counting the start cycle), cs_n never low
        set_seg(0, 24'h000000, 14'h0000, 16'd0);
        cb = cs_falls; wb = wr_a.size(); busy_cnt = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk("t5_busy_cycles", 32'(busy_cnt), 32'(SEGS + 1));
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_cs_windows", 32'(cs_falls - cb), 32'd0);
        chk("t5_no_writes", 32'(wr_a.size() - wb), 32'd0);

        // random handshake delays plus an ignored second start
        rand_dly = 1'b1;
        slot = 4'd2;
        set_seg(0, 24'h000000, 14'h1000, 16'd2);
        set_seg(1, 24'h000010, 14'h2000, 16'd3);
        sb = spi_log.size(); wb = wr_a.size();
        pulse_start();
        repeat (10) @(negedge clk);
        chk("t6_busy_mid", 32'(busy), 32'd1);
        pulse_start();
        wait_done(3000);
        repeat (20) @(negedge clk);
        chk("t6_idle_after", 32'(busy), 32'd0);
        for (int i = 0; i < 13; i++) chk_spi(sb + i, e2[i]);
        chk("t6_spi_count", 32'(spi_log.size() - sb), 32'd13);
        chk_wr(wb + 0, 14'h1000, 8'h11, 3'd0); chk_wr(wb + 1, 14'h1001, 8'h22, 3'd0);
        chk_wr(wb + 2, 14'h2000, 8'h33, 3'd1); chk_wr(wb + 3, 14'h2001, 8'h44, 3'd1);
        chk_wr(wb + 4, 14'h2002, 8'h55, 3'd1);
        chk("t6_wr_count", 32'(wr_a.size() - wb), 32'd5);
        rand_dly = 1'b0;

        // reset while the second data byte is being read
        set_seg(0, 24'h000100, 14'h0000, 16'd4);
        set_seg(1, 24'h000000, 14'h0000, 16'd0);
        sb = spi_log.size();
        pulse_start();
        begin : wait_read2
            bit ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (spi_log.size() >= sb + 6) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            chk("t7_reached_read2", 32'(ok), 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("t7_cs_n", 32'(cs_n), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_req", 32'(req), 32'd0);
        chk("t7_spi_req", 32'(spi_req), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        sb = spi_log.size(); wb = wr_a.size();
        pulse_start();
        wait_done(500);
        chk_spi(sb + 0, 8'h03); chk_spi(sb + 2, 8'h01);
        chk_wr(wb + 0, 14'h0000, 8'hAA, 3'd0); chk_wr(wb + 3, 14'h0003, 8'hDD, 3'd0);
        chk("t7_wr_count", 32'(wr_a.size() - wb), 32'd4);

        chk("spi_protocol_violations", 32'(spi_viol), 32'd0);
        chk("mem_protocol_violations", 32'(mem_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
